// File: rtl/ahb3lite_gpio_debounce.sv
// AHB3-Lite GPIO slave: CPU-driven outputs with atomic set/clear, debounced inputs,
// and maskable per-channel rising/falling edge events combined into a level interrupt.
module ahb3lite_gpio_debounce #(
   parameter int HADDR_SIZE        = 32,
   parameter int HDATA_SIZE        = 32,
   parameter int g_num_out         = 8,
   parameter int g_num_in          = 4,
   parameter int g_debounce_cycles = 10000
) (
   input  logic                  hclk_i,
   input  logic                  hreset_i,
   input  logic                  hsel_i,
   input  logic [HADDR_SIZE-1:0] haddr_i,
   input  logic [HDATA_SIZE-1:0] hwdata_i,
   output logic [HDATA_SIZE-1:0] hrdata_o,
   input  logic                  hwrite_i,
   input  logic [2:0]            hsize_i,
   input  logic [2:0]            hburst_i,
   input  logic [3:0]            hprot_i,
   input  logic [1:0]            htrans_i,
   input  logic                  hready_i,
   output logic                  hreadyout_o,
   output logic                  hresp_o,
   input  logic [g_num_in-1:0]   gpio_i,
   output logic [g_num_out-1:0]  gpio_o,
   output logic                  irq_o
);

   typedef enum logic [2:0] {
      REG_OUT     = 3'd0,
      REG_OUT_SET = 3'd1,
      REG_OUT_CLR = 3'd2,
      REG_IN      = 3'd3,
      REG_EDGE_EN = 3'd4,
      REG_EVENT   = 3'd5,
      REG_IRQ_EN  = 3'd6,
      REG_RSVD    = 3'd7
   } reg_e;

   localparam int CW = (g_debounce_cycles > 1) ? $clog2(g_debounce_cycles) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(g_debounce_cycles - 1);
   localparam logic [HDATA_SIZE-1:0] IN_MASK = HDATA_SIZE'((64'd1 << g_num_in) - 64'd1);
   localparam logic [HDATA_SIZE-1:0] EV_MASK = IN_MASK | (IN_MASK << 16);

   logic                  accept;
   logic                  rd_q, wr_q;
   reg_e                  addr_q;
   logic [g_num_out-1:0]  wdata_out;
   logic [g_num_out-1:0]  out_q, out_d;
   logic [g_num_in-1:0]   sync1_q, sync2_q, stable_q;
   logic [g_num_in-1:0]   settle, rise, fall;
   logic [CW-1:0]         cnt_q [g_num_in];
   logic [HDATA_SIZE-1:0] edge_en_q, edge_en_d;
   logic [HDATA_SIZE-1:0] event_q, event_d;
   logic [HDATA_SIZE-1:0] irq_en_q, irq_en_d;
   logic [HDATA_SIZE-1:0] ev_set;
   logic                  irq_q;
   logic                  unused_bits;

   assign accept    = hsel_i & hready_i & htrans_i[1];
   assign wdata_out = hwdata_i[g_num_out-1:0];

   // A channel settles when the synchronised pin has differed from the
   // stable value for the full debounce window.
   always_comb begin
      settle = '0;
      for (int i = 0; i < g_num_in; i++) begin
         settle[i] = (sync2_q[i] != stable_q[i]) && (cnt_q[i] == CNT_LAST);
      end
   end

   assign rise   = settle & sync2_q;
   assign fall   = settle & ~sync2_q;
   assign ev_set = ((HDATA_SIZE'(fall) << 16) | HDATA_SIZE'(rise)) & edge_en_q;

   // NOTE: every next-state gets its hold value first so no path infers a latch.
   always_comb begin
      out_d     = out_q;
      edge_en_d = edge_en_q;
      irq_en_d  = irq_en_q;
      event_d   = event_q | ev_set;
      if (wr_q) begin
         case (addr_q)
            REG_OUT:     out_d     = wdata_out;
            REG_OUT_SET: out_d     = out_q | wdata_out;
            REG_OUT_CLR: out_d     = out_q & ~wdata_out;
            REG_EDGE_EN: edge_en_d = hwdata_i & EV_MASK;
            REG_EVENT:   event_d   = (event_q & ~hwdata_i) | ev_set;
            REG_IRQ_EN:  irq_en_d  = hwdata_i & EV_MASK;
            default:     ;
         endcase
      end
   end

   always_comb begin
      hrdata_o = '0;
      if (rd_q) begin
         case (addr_q)
            REG_OUT:     hrdata_o = HDATA_SIZE'(out_q);
            REG_IN:      hrdata_o = HDATA_SIZE'(stable_q);
            REG_EDGE_EN: hrdata_o = edge_en_q;
            REG_EVENT:   hrdata_o = event_q;
            REG_IRQ_EN:  hrdata_o = irq_en_q;
            default:     hrdata_o = '0;
         endcase
      end
   end

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= REG_OUT;
         out_q     <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         // NOTE: the counter array is reset too, so a reset always restarts debouncing cleanly.
         for (int i = 0; i < g_num_in; i++) cnt_q[i] <= '0;
         edge_en_q <= '0;
         event_q   <= '0;
         irq_en_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         rd_q      <= accept & ~hwrite_i;
         wr_q      <= accept & hwrite_i;
         if (accept) addr_q <= reg_e'(haddr_i[4:2]);
         out_q     <= out_d;
         sync1_q   <= gpio_i;
         sync2_q   <= sync1_q;
         for (int i = 0; i < g_num_in; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (settle[i]) begin
               stable_q[i] <= sync2_q[i];
               cnt_q[i]    <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
         edge_en_q <= edge_en_d;
         event_q   <= event_d;
         irq_en_q  <= irq_en_d;
         irq_q     <= |(event_q & irq_en_q);
      end
   end

   assign gpio_o      = out_q;
   assign irq_o       = irq_q;
   assign hreadyout_o = 1'b1;
   assign hresp_o     = 1'b0;

   assign unused_bits = ^{hsize_i, hburst_i, hprot_i, htrans_i[0],
                          haddr_i[HADDR_SIZE-1:5], haddr_i[1:0]};

endmodule

// File: tb/tb_ahb3lite_gpio_debounce.sv
// Directed bench for ahb3lite_gpio_debounce with an 4-cycle debounce window.
module tb_ahb3lite_gpio_debounce;

   localparam int N_OUT = 8;
   localparam int N_IN  = 4;
   localparam int DB    = 4;

   localparam logic [31:0] A_OUT     = 32'h00;
   localparam logic [31:0] A_OUT_SET = 32'h04;
   localparam logic [31:0] A_OUT_CLR = 32'h08;
   localparam logic [31:0] A_IN      = 32'h0C;
   localparam logic [31:0] A_EDGE_EN = 32'h10;
   localparam logic [31:0] A_EVENT   = 32'h14;
   localparam logic [31:0] A_IRQ_EN  = 32'h18;

   logic             hclk = 1'b0;
   logic             hreset;
   logic             hsel;
   logic [31:0]      haddr;
   logic [31:0]      hwdata;
   logic [31:0]      hrdata;
   logic             hwrite;
   logic [2:0]       hsize;
   logic [2:0]       hburst;
   logic [3:0]       hprot;
   logic [1:0]       htrans;
   logic             hready;
   logic             hreadyout;
   logic             hresp;
   logic [N_IN-1:0]  gpio_in;
   logic [N_OUT-1:0] gpio_out;
   logic             irq;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rd;

   always #5 hclk = ~hclk;

   ahb3lite_gpio_debounce #(
      .HADDR_SIZE(32), .HDATA_SIZE(32),
      .g_num_out(N_OUT), .g_num_in(N_IN), .g_debounce_cycles(DB)
   ) dut (
      .hclk_i(hclk), .hreset_i(hreset), .hsel_i(hsel), .haddr_i(haddr),
      .hwdata_i(hwdata), .hrdata_o(hrdata), .hwrite_i(hwrite), .hsize_i(hsize),
      .hburst_i(hburst), .hprot_i(hprot), .htrans_i(htrans), .hready_i(hready),
      .hreadyout_o(hreadyout), .hresp_o(hresp), .gpio_i(gpio_in),
      .gpio_o(gpio_out), .irq_o(irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
   endtask

   task automatic addr_phase(input logic [31:0] addr, input logic wr);
      hsel   = 1'b1;
      htrans = 2'b10;
      hwrite = wr;
      haddr  = addr;
   endtask

   task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge hclk);
      addr_phase(addr, 1'b1);
      @(negedge hclk);
      bus_idle();
      hwdata = data;
   endtask

   task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge hclk);
      addr_phase(addr, 1'b0);
      @(negedge hclk);
      bus_idle();
      data = hrdata;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge hclk);
   endtask

   task automatic check_all_zero(input string pfx);
      for (int a = 0; a < 8; a++) begin
         ahb_read(32'(a * 4), rd);
         check($sformatf("%s_rd_%02h", pfx, a * 4), rd, 32'h0);
      end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      hreset  = 1'b1;
      hsel    = 1'b0;
      haddr   = '0;
      hwdata  = '0;
      hwrite  = 1'b0;
      hsize   = 3'b010;
      hburst  = 3'b000;
      hprot   = 4'b0011;
      htrans  = 2'b00;
      hready  = 1'b1;
      gpio_in = '0;
      wait_cycles(3);
      hreset = 1'b0;
      @(negedge hclk);

      // Reset state
      check("rst_gpio", 32'(gpio_out), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_hready", 32'(hreadyout), 32'h1);
      check("rst_hresp", 32'(hresp), 32'h0);
      check("rst_hrdata", hrdata, 32'h0);
      check_all_zero("rst");

      // Output register with atomic set/clear
      ahb_write(A_OUT, 32'hA5);
      @(negedge hclk);
      check("out_write", 32'(gpio_out), 32'hA5);
      ahb_write(A_OUT_SET, 32'h0F);
      @(negedge hclk);
      check("out_set", 32'(gpio_out), 32'hAF);
      ahb_write(A_OUT_CLR, 32'h81);
      @(negedge hclk);
      check("out_clr", 32'(gpio_out), 32'h2E);
      ahb_read(A_OUT, rd);
      check("out_rd", rd, 32'h2E);
      ahb_read(A_OUT_SET, rd);
      check("out_set_rd", rd, 32'h0);
      ahb_read(A_OUT_CLR, rd);
      check("out_clr_rd", rd, 32'h0);

      // IDLE transfer and deselected write have no effect
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = A_OUT;
      @(negedge hclk);
      hsel = 1'b0; htrans = 2'b10; hwdata = 32'hFF;
      @(negedge hclk);
      bus_idle();
      hwdata = 32'hFF;
      wait_cycles(2);
      check("idle_no_write", 32'(gpio_out), 32'h2E);
      check("hready_mid", 32'(hreadyout), 32'h1);

      // Glitch of 3 cycles is rejected
      @(negedge hclk);
      gpio_in[0] = 1'b1;
      wait_cycles(3);
      gpio_in[0] = 1'b0;
      wait_cycles(4);
      ahb_read(A_IN, rd);
      check("glitch_in_a", rd, 32'h0);
      ahb_read(A_IN, rd);
      check("glitch_in_b", rd, 32'h0);

      // Held input is accepted exactly 6 cycles after the pin change
      @(negedge hclk);
      gpio_in[0] = 1'b1;
      addr_phase(A_IN, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge hclk);
         check($sformatf("hold_in_c%0d", k), hrdata, (k >= 6) ? 32'h1 : 32'h0);
      end
      bus_idle();
      wait_cycles(4);
      gpio_in[0] = 1'b0;
      wait_cycles(10);
      ahb_read(A_IN, rd);
      check("hold_in_release", rd, 32'h0);

      // Edge events and interrupt
      ahb_write(A_EDGE_EN, 32'hFFFF_FFFF);
      ahb_read(A_EDGE_EN, rd);
      check("edge_en_mask", rd, 32'h000F_000F);
      ahb_write(A_EDGE_EN, 32'h0001_0001);
      ahb_write(A_IRQ_EN, 32'h0000_0001);
      ahb_read(A_IRQ_EN, rd);
      check("irq_en_rd", rd, 32'h0000_0001);

      @(negedge hclk);
      gpio_in[0] = 1'b1;
      addr_phase(A_EVENT, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge hclk);
         check($sformatf("rise_ev_c%0d", k), hrdata, (k >= 6) ? 32'h1 : 32'h0);
         check($sformatf("rise_irq_c%0d", k), 32'(irq), (k >= 7) ? 32'h1 : 32'h0);
      end
      bus_idle();
      wait_cycles(2);
      gpio_in[0] = 1'b0;
      wait_cycles(10);
      ahb_read(A_EVENT, rd);
      check("fall_ev", rd, 32'h0001_0001);
      check("fall_irq", 32'(irq), 32'h1);

      ahb_write(A_EVENT, 32'h1);
      @(negedge hclk);
      check("clr_irq_lag", 32'(irq), 32'h1);
      @(negedge hclk);
      check("clr_irq_low", 32'(irq), 32'h0);
      ahb_read(A_EVENT, rd);
      check("clr_ev", rd, 32'h0001_0000);

      // Set wins over a simultaneous W1C
      gpio_in[0] = 1'b1;
      wait_cycles(10);
      ahb_read(A_EVENT, rd);
      check("pre_col_ev", rd, 32'h0001_0001);
      check("pre_col_irq", 32'(irq), 32'h1);
      gpio_in[0] = 1'b0;
      wait_cycles(10);
      @(negedge hclk);
      gpio_in[0] = 1'b1;
      wait_cycles(3);
      @(negedge hclk);
      addr_phase(A_EVENT, 1'b1);
      @(negedge hclk);
      bus_idle();
      hwdata = 32'h1;
      for (int k = 5; k <= 8; k++) begin
         check($sformatf("col_irq_c%0d", k), 32'(irq), 32'h1);
         @(negedge hclk);
      end
      ahb_read(A_EVENT, rd);
      check("col_ev", rd, 32'h0001_0001);
      gpio_in[0] = 1'b0;
      wait_cycles(10);

      // Reset during a write data phase discards the write
      ahb_write(A_OUT, 32'h0);
      @(negedge hclk);
      check("pre_rst_gpio", 32'(gpio_out), 32'h0);
      addr_phase(A_OUT, 1'b1);
      @(negedge hclk);
      bus_idle();
      hwdata = 32'hFF;
      hreset = 1'b1;
      @(negedge hclk);
      check("rst_abort_gpio", 32'(gpio_out), 32'h0);
      hreset = 1'b0;
      @(negedge hclk);
      check("rst_abort_gpio_after", 32'(gpio_out), 32'h0);
      check("rst_abort_irq", 32'(irq), 32'h0);
      check_all_zero("rst2");
      check("end_hready", 32'(hreadyout), 32'h1);
      check("end_hresp", 32'(hresp), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
